ulpi_init_seq: RTL



---
 rtl/ulpi_pkg.sv | 35 +++
 rtl/ulpi_init_rom.sv | 31 +++
 rtl/ulpi_init_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_pkg.sv
// Shared definitions for the ULPI PHY init sequencer:
// register addresses, sequencer states, error codes, step record.
package ulpi_pkg;

    localparam logic [5:0] VID_LO    = 6'h00;
    localparam logic [5:0] FUNC_CTRL = 6'h04;
    localparam logic [5:0] OTG_CTRL  = 6'h0A;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_RETRY    = 2'b01;
    localparam logic [1:0] ERR_MISMATCH = 2'b10;

    localparam logic [2:0] LAST_STEP = 3'd4;

    typedef enum logic [3:0] {
        S_WAIT_READY,
        S_SETTLE,
        S_ISSUE,
        S_WAIT_RESP,
        S_CHECK,
        S_RETRY,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    typedef struct packed {
        logic       rw;
        logic [5:0] addr;
        logic [7:0] data;
        logic       chk;
        logic [7:0] exp_val;
    } step_t;

endpackage

// File: rtl/ulpi_init_rom.sv
// Step table of the init sequence (combinational).
// Ports: step (index 0..4) in; ent (rw/addr/data/chk/exp_val) out.
module ulpi_init_rom
    import ulpi_pkg::*;
#(
    parameter logic [7:0] FUNC_CTRL_VAL = 8'h45,
    parameter logic [7:0] OTG_CTRL_VAL  = 8'h00,
    parameter logic [7:0] VID_LO_EXP    = 8'h24
) (
    input  logic [2:0] step,
    output step_t      ent
);

    always_comb begin
        ent = '0;
        unique case (step)
            3'd0: ent = '{rw: 1'b0, addr: VID_LO, data: 8'h00,
                          chk: 1'b1, exp_val: VID_LO_EXP};
            3'd1: ent = '{rw: 1'b1, addr: FUNC_CTRL, data: FUNC_CTRL_VAL,
                          chk: 1'b0, exp_val: 8'h00};
            3'd2: ent = '{rw: 1'b1, addr: OTG_CTRL, data: OTG_CTRL_VAL,
                          chk: 1'b0, exp_val: 8'h00};
            3'd3: ent = '{rw: 1'b0, addr: FUNC_CTRL, data: 8'h00,
                          chk: 1'b1, exp_val: FUNC_CTRL_VAL};
            3'd4: ent = '{rw: 1'b0, addr: OTG_CTRL, data: 8'h00,
                          chk: 1'b1, exp_val: OTG_CTRL_VAL};
            default: ent = '0;
        endcase
    end

endmodule

// File: rtl/ulpi_init_seq.sv
// ULPI PHY init sequencer: after link READY, runs the step table
// with retries and verifies readbacks.
// Ports: CLK_60M/NRST_A_USB; ULPI_READY, REG_DONE/FAIL/DATA_O from link;
// REG_EN/RW/ADDR/DATA_I to link; RESTART in;
// INIT_BUSY/DONE/ERR, ERR_CODE, ERR_STEP status out (all registered).
module ulpi_init_seq
    import ulpi_pkg::*;
#(
    parameter logic [7:0] FUNC_CTRL_VAL = 8'h45,
    parameter logic [7:0] OTG_CTRL_VAL  = 8'h00,
    parameter logic [7:0] VID_LO_EXP    = 8'h24,
    parameter int         SETTLE_CYC    = 60,
    parameter int         TIMEOUT_CYC   = 1023,
    parameter int         MAX_RETRY     = 3
) (
    input  logic       CLK_60M,
    input  logic       NRST_A_USB,
    input  logic       ULPI_READY,
    input  logic       REG_DONE,
    input  logic       REG_FAIL,
    input  logic [7:0] REG_DATA_O,
    input  logic       RESTART,
    output logic       REG_EN,
    output logic       REG_RW,
    output logic [5:0] REG_ADDR,
    output logic [7:0] REG_DATA_I,
    output logic       INIT_BUSY,
    output logic       INIT_DONE,
    output logic       INIT_ERR,
    output logic [1:0] ERR_CODE,
    output logic [2:0] ERR_STEP
);

    localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYC - 1);
    localparam logic [9:0] TO_LAST     = 10'(TIMEOUT_CYC);
    localparam logic [1:0] RETRY_LIM   = 2'(MAX_RETRY);

    state_t     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [1:0] retry_q, retry_d;
    logic [9:0] cnt_q, cnt_d;
    logic [7:0] rdata_q, rdata_d;
    logic       mism_q, mism_d;
    logic       adv_q, adv_d;
    logic       en_q, en_d;
    logic       rw_q, rw_d;
    logic [5:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [1:0] code_q, code_d;
    logic [2:0] estep_q, estep_d;
    logic       abort;
    step_t      ent;

    ulpi_init_rom #(
        .FUNC_CTRL_VAL (FUNC_CTRL_VAL),
        .OTG_CTRL_VAL  (OTG_CTRL_VAL),
        .VID_LO_EXP    (VID_LO_EXP)
    ) u_rom (
        .step (step_q),
        .ent  (ent)
    );

    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            state_q <= S_WAIT_READY;
            step_q  <= '0;
            retry_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            mism_q  <= 1'b0;
            adv_q   <= 1'b0;
            en_q    <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            estep_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mism_q  <= mism_d;
            adv_q   <= adv_d;
            en_q    <= en_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            estep_q <= estep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mism_d  = mism_q;
        adv_d   = adv_q;
        en_d    = en_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        code_d  = code_q;
        estep_d = estep_q;
        abort   = 1'b0;

        unique case (state_q)
            S_WAIT_READY: begin
                if (ULPI_READY) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (!ULPI_READY) begin
                    state_d = S_WAIT_READY;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_ISSUE;
                    busy_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            S_ISSUE: begin
                if (!ULPI_READY) begin
                    abort = 1'b1;
                end else begin
                    en_d    = 1'b1;
                    rw_d    = ent.rw;
                    addr_d  = ent.addr;
                    wdata_d = ent.rw ? ent.data : 8'h00;
                    cnt_d   = '0;
                    state_d = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                // FAIL wins over a simultaneous DONE
                if (!ULPI_READY) begin
                    abort = 1'b1;
                end else if (REG_FAIL) begin
                    en_d    = 1'b0;
                    mism_d  = 1'b0;
                    state_d = S_RETRY;
                end else if (REG_DONE) begin
                    en_d    = 1'b0;
                    rdata_d = REG_DATA_O;
                    state_d = S_CHECK;
                end else if (cnt_q == TO_LAST) begin
                    en_d    = 1'b0;
                    mism_d  = 1'b0;
                    state_d = S_RETRY;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            S_CHECK: begin
                if (!ULPI_READY) begin
                    abort = 1'b1;
                end else if (ent.chk && rdata_q != ent.exp_val) begin
                    mism_d  = 1'b1;
                    state_d = S_RETRY;
                end else begin
                    retry_d = '0;
                    adv_d   = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_RETRY: begin
                if (!ULPI_READY) begin
                    abort = 1'b1;
                end else if (retry_q < RETRY_LIM) begin
                    retry_d = retry_q + 2'd1;
                    adv_d   = 1'b0;
                    state_d = S_GAP;
                end else begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    code_d  = mism_q ? ERR_MISMATCH : ERR_RETRY;
                    estep_d = step_q;
                    state_d = S_ERROR;
                end
            end
            S_GAP: begin
                // adv_q marks a passed step; a retry reissues it
                adv_d = 1'b0;
                if (!ULPI_READY) begin
                    abort = 1'b1;
                end else if (adv_q && step_q == LAST_STEP) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    if (adv_q) begin
                        step_d = step_q + 3'd1;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                if (!ULPI_READY || RESTART) begin
                    done_d  = 1'b0;
                    step_d  = '0;
                    retry_d = '0;
                    state_d = S_WAIT_READY;
                end
            end
            S_ERROR: begin
                if (RESTART) begin
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                    estep_d = '0;
                    step_d  = '0;
                    retry_d = '0;
                    state_d = S_WAIT_READY;
                end
            end
            default: state_d = S_WAIT_READY;
        endcase

        // link core went back into reset: start over
        if (abort) begin
            en_d    = 1'b0;
            step_d  = '0;
            retry_d = '0;
            adv_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = S_WAIT_READY;
        end
    end

    assign REG_EN     = en_q;
    assign REG_RW     = rw_q;
    assign REG_ADDR   = addr_q;
    assign REG_DATA_I = wdata_q;
    assign INIT_BUSY  = busy_q;
    assign INIT_DONE  = done_q;
    assign INIT_ERR   = err_q;
    assign ERR_CODE   = code_q;
    assign ERR_STEP   = estep_q;

endmodule
